// File: rtl/fnd_scan_ctrl_pkg.sv
// fnd_scan_ctrl_pkg
//   Shared definitions for the multiplexed seven-segment scanner:
//   - FSM state encodings.
//   - Active-high segment patterns for the hex digits 0..F.
//   - Bit positions of the segments inside the 8-bit {dp,g,f,e,d,c,b,a} bus.
//   - A small one-hot helper for the digit commons.
package fnd_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // Segment bit order on the output bus: a is bit 0, g is bit 6, dp is bit 7.
  localparam int SEG_A_BIT  = 0;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  // Active-high gfedcba patterns.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // One-hot select for an 8-digit common bus.
  function automatic logic [7:0] onehot8(input logic [2:0] pos);
    onehot8 = 8'b1 << pos;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_seg7_decode.sv
// seg7_decode
//   Combinational hex-to-seven-segment decoder, active-high, no dp.
//   Ports:
//     i_num  in  4  nibble to display (0..F)
//     o_pat  out 7  gfedcba pattern, 1 = segment lit
module seg7_decode
  import fnd_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_num,
  output logic [6:0] o_pat
);

  // Plain lookup of the nibble; polarity and dp are applied by the caller.
  always_comb begin
    o_pat = SEG_0;
    case (i_num)
      4'h0: o_pat = SEG_0;
      4'h1: o_pat = SEG_1;
      4'h2: o_pat = SEG_2;
      4'h3: o_pat = SEG_3;
      4'h4: o_pat = SEG_4;
      4'h5: o_pat = SEG_5;
      4'h6: o_pat = SEG_6;
      4'h7: o_pat = SEG_7;
      4'h8: o_pat = SEG_8;
      4'h9: o_pat = SEG_9;
      4'hA: o_pat = SEG_A;
      4'hB: o_pat = SEG_B;
      4'hC: o_pat = SEG_C;
      4'hD: o_pat = SEG_D;
      4'hE: o_pat = SEG_E;
      4'hF: o_pat = SEG_F;
      default: o_pat = SEG_0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
//   Scans an 8-digit multiplexed seven-segment display. Each digit gets a
//   BLANK gap (all commons off, lets the external digit mux settle and kills
//   ghosting) followed by a SHOW phase where exactly one common is driven.
//   Ports:
//     i_clk         in   1  system clock
//     i_rst_n       in   1  asynchronous active-low reset
//     i_en          in   1  scan enable; 0 turns the display off
//     i_num         in   4  nibble for the current o_pos from the digit selector
//     i_blank_mask  in   8  bit k=1: digit k shows no a-g segments
//     i_dp_mask     in   8  bit k=1: decimal point of digit k lit
//     o_pos         out  3  scan position to the digit selector
//     o_com         out  8  digit commons, bit k drives digit k
//     o_seg         out  8  {dp,g,f,e,d,c,b,a}
//     o_frame_tick  out  1  one-cycle pulse after digit 7 completes
module fnd_scan_ctrl
  import fnd_scan_ctrl_pkg::*;
#(
  parameter int DIV_CNT     = 100000,
  parameter int BLANK_CNT   = 1000,
  parameter bit COM_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [3:0] i_num,
  input  logic [7:0] i_blank_mask,
  input  logic [7:0] i_dp_mask,
  output logic [2:0] o_pos,
  output logic [7:0] o_com,
  output logic [7:0] o_seg,
  output logic       o_frame_tick
);

  localparam int MAX_CNT = (DIV_CNT > BLANK_CNT) ? DIV_CNT : BLANK_CNT;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CNT - 1);
  localparam logic [7:0] COM_OFF = COM_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pos_q, pos_d;
  logic [3:0]       num_q, num_d;
  logic             blank_q, blank_d;
  logic             dp_q, dp_d;
  logic [7:0]       com_q, com_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick_q, tick_d;
  logic [6:0]       pat;
  logic [7:0]       seg_on;

  // Decode the nibble that will be on display next cycle, so the segment
  // register lands together with the state change into SHOW.
  seg7_decode u_decode (
    .i_num (num_d),
    .o_pat (pat)
  );

  // Next-state logic. Disable takes priority over every phase transition.
  // The nibble and both mask bits are captured together on the last BLANK
  // cycle so nothing the selector does later can change a lit digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    num_d   = num_q;
    blank_d = blank_q;
    dp_d    = dp_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (!i_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          num_d   = i_num;
          blank_d = i_blank_mask[pos_q];
          dp_d    = i_dp_mask[pos_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (!i_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DIV_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          pos_d   = pos_q + 3'd1;
          tick_d  = (pos_q == 3'd7);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values derived from the next state: only SHOW drives a common,
  // which keeps the one-common-at-most invariant structural.
  always_comb begin
    seg_on = '0;
    seg_on[SEG_G_BIT:SEG_A_BIT] = blank_d ? 7'h00 : pat;
    seg_on[SEG_DP_BIT] = dp_d;
    com_d = COM_OFF;
    seg_d = SEG_OFF;
    if (state_d == ST_SHOW) begin
      com_d = COM_ACT_LOW ? ~onehot8(pos_d) : onehot8(pos_d);
      seg_d = SEG_ACT_LOW ? ~seg_on : seg_on;
    end
  end

  // Single register bank for the FSM and every output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      num_q   <= '0;
      blank_q <= 1'b0;
      dp_q    <= 1'b0;
      com_q   <= COM_OFF;
      seg_q   <= SEG_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      num_q   <= num_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      com_q   <= com_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end

  assign o_pos        = pos_q;
  assign o_com        = com_q;
  assign o_seg        = seg_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl
//   Directed bench for fnd_scan_ctrl with DIV_CNT=4, BLANK_CNT=2 and
//   active-low commons and segments. A digit period is 6 cycles: 2 blank
//   then 4 lit; a frame is 48 cycles.
module tb_fnd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] num_in;
  logic [3:0] num_drv = 4'h0;
  logic       use_mux = 1'b1;
  logic [7:0] blank_mask = 8'h00;
  logic [7:0] dp_mask = 8'h00;
  logic [2:0] o_pos;
  logic [7:0] o_com;
  logic [7:0] o_seg;
  logic       o_frame_tick;

  int errors = 0;
  int checks = 0;

  fnd_scan_ctrl #(
    .DIV_CNT     (4),
    .BLANK_CNT   (2),
    .COM_ACT_LOW (1'b1),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_num        (num_in),
    .i_blank_mask (blank_mask),
    .i_dp_mask    (dp_mask),
    .o_pos        (o_pos),
    .o_com        (o_com),
    .o_seg        (o_seg),
    .o_frame_tick (o_frame_tick)
  );

  always #5 clk = ~clk;

  // Model digit selector: returns the position itself, or a driven value.
  always_comb begin
    num_in = use_mux ? {1'b0, o_pos} : num_drv;
  end

  // Expected active-high gfedcba patterns for 0..F.
  function automatic logic [6:0] exp_pat(input logic [3:0] v);
    case (v)
      4'h0: exp_pat = 7'h3F;  4'h1: exp_pat = 7'h06;
      4'h2: exp_pat = 7'h5B;  4'h3: exp_pat = 7'h4F;
      4'h4: exp_pat = 7'h66;  4'h5: exp_pat = 7'h6D;
      4'h6: exp_pat = 7'h7D;  4'h7: exp_pat = 7'h07;
      4'h8: exp_pat = 7'h7F;  4'h9: exp_pat = 7'h6F;
      4'hA: exp_pat = 7'h77;  4'hB: exp_pat = 7'h7C;
      4'hC: exp_pat = 7'h39;  4'hD: exp_pat = 7'h5E;
      4'hE: exp_pat = 7'h79;  default: exp_pat = 7'h71;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release with the scanner idle, then enable. The next tick()
  // lands in the first BLANK cycle of digit 0.
  task automatic restart();
    rst_n = 1'b0; en = 1'b0; use_mux = 1'b1; num_drv = 4'h0;
    blank_mask = 8'h00; dp_mask = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    repeat (3) tick();
    checks++;
    if (o_com !== 8'hFF || o_seg !== 8'hFF || o_pos !== 3'd0 || o_frame_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold got com=%h seg=%h pos=%0d tick=%b exp com=ff seg=ff pos=0 tick=0",
               o_com, o_seg, o_pos, o_frame_tick);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++;
      if (o_com !== 8'hFF || o_seg !== 8'hFF || o_pos !== 3'd0 || o_frame_tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle n=%0d got com=%h seg=%h pos=%0d tick=%b exp com=ff seg=ff pos=0 tick=0",
                 n, o_com, o_seg, o_pos, o_frame_tick);
      end
    end
  endtask

  task automatic test_scan();
    restart();
    for (int n = 0; n < 96; n++) begin
      int k, j;
      logic [7:0] ec, es;
      logic et;
      tick();
      k  = (n / 6) % 8;
      j  = n % 6;
      ec = (j < 2) ? 8'hFF : ~(8'h01 << k);
      es = (j < 2) ? 8'hFF : ~{1'b0, exp_pat(k[3:0])};
      et = (n == 48);
      checks++;
      if (o_com !== ec || o_seg !== es || o_pos !== k[2:0] || o_frame_tick !== et) begin
        errors++;
        $display("[TB] FAIL scan n=%0d got com=%h seg=%h pos=%0d tick=%b exp com=%h seg=%h pos=%0d tick=%b",
                 n, o_com, o_seg, o_pos, o_frame_tick, ec, es, k, et);
      end
    end
  endtask

  task automatic test_num_change();
    restart();
    use_mux = 1'b0;
    for (int n = 0; n < 48; n++) begin
      int k, j;
      logic [3:0] shown;
      logic [7:0] es;
      tick();
      k = n / 6;
      j = n % 6;
      shown = 4'(k + 3);
      es = ~{1'b0, exp_pat(shown)};
      if (j >= 2) begin
        checks++;
        if (o_seg !== es || o_com !== ~(8'h01 << k)) begin
          errors++;
          $display("[TB] FAIL num_change n=%0d got com=%h seg=%h exp com=%h seg=%h",
                   n, o_com, o_seg, ~(8'h01 << k), es);
        end
      end
      num_drv = (j == 0) ? 4'hE : (j == 1) ? shown : 4'h8;
    end
  endtask

  task automatic test_masks();
    restart();
    blank_mask = 8'h80;
    dp_mask    = 8'h04;
    for (int n = 0; n < 48; n++) begin
      int k, j;
      logic [7:0] es;
      tick();
      k = n / 6;
      j = n % 6;
      if (k == 7)      es = 8'hFF;
      else if (k == 2) es = 8'h24;
      else             es = ~{1'b0, exp_pat(k[3:0])};
      if (j >= 2) begin
        checks++;
        if (o_seg !== es || o_com !== ~(8'h01 << k)) begin
          errors++;
          $display("[TB] FAIL masks n=%0d got com=%h seg=%h exp com=%h seg=%h",
                   n, o_com, o_seg, ~(8'h01 << k), es);
        end
      end
    end
  endtask

  task automatic test_hex();
    restart();
    use_mux = 1'b0;
    for (int n = 0; n < 48; n++) begin
      int k, j;
      logic [7:0] es;
      k = n / 6;
      num_drv = (k >= 2) ? 4'(k + 8) : 4'(k);
      tick();
      j = n % 6;
      case (k)
        2: es = ~8'h77;  3: es = ~8'h7C;  4: es = ~8'h39;
        5: es = ~8'h5E;  6: es = ~8'h79;  7: es = ~8'h71;
        default: es = ~{1'b0, exp_pat(k[3:0])};
      endcase
      if (j >= 2 && k >= 2) begin
        checks++;
        if (o_seg !== es) begin
          errors++;
          $display("[TB] FAIL hex n=%0d got seg=%h exp seg=%h", n, o_seg, es);
        end
      end
    end
  endtask

  task automatic test_disable();
    restart();
    for (int n = 0; n <= 34; n++) tick();
    checks++;
    if (o_com !== 8'hDF || o_pos !== 3'd5) begin
      errors++;
      $display("[TB] FAIL disable_pre got com=%h pos=%0d exp com=df pos=5", o_com, o_pos);
    end
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (o_com !== 8'hFF || o_seg !== 8'hFF || o_pos !== 3'd5 || o_frame_tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL disable_idle n=%0d got com=%h seg=%h pos=%0d tick=%b exp com=ff seg=ff pos=5 tick=0",
                 n, o_com, o_seg, o_pos, o_frame_tick);
      end
    end
    en = 1'b1;
    for (int j = 0; j < 7; j++) begin
      logic [7:0] ec, es;
      logic [2:0] ep;
      tick();
      ec = (j >= 2 && j < 6) ? 8'hDF : 8'hFF;
      es = (j >= 2 && j < 6) ? ~{1'b0, 7'h6D} : 8'hFF;
      ep = (j == 6) ? 3'd6 : 3'd5;
      checks++;
      if (o_com !== ec || o_seg !== es || o_pos !== ep) begin
        errors++;
        $display("[TB] FAIL reenable j=%0d got com=%h seg=%h pos=%0d exp com=%h seg=%h pos=%0d",
                 j, o_com, o_seg, o_pos, ec, es, ep);
      end
    end
  endtask

  task automatic test_async_reset();
    restart();
    for (int n = 0; n <= 21; n++) tick();
    checks++;
    if (o_com !== 8'hF7 || o_pos !== 3'd3) begin
      errors++;
      $display("[TB] FAIL areset_pre got com=%h pos=%0d exp com=f7 pos=3", o_com, o_pos);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_com !== 8'hFF || o_seg !== 8'hFF || o_pos !== 3'd0 || o_frame_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_async got com=%h seg=%h pos=%0d tick=%b exp com=ff seg=ff pos=0 tick=0",
               o_com, o_seg, o_pos, o_frame_tick);
    end
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      int k, j;
      logic [7:0] ec;
      tick();
      k  = n / 6;
      j  = n % 6;
      ec = (j < 2) ? 8'hFF : ~(8'h01 << k);
      checks++;
      if (o_com !== ec || o_pos !== k[2:0]) begin
        errors++;
        $display("[TB] FAIL areset_restart n=%0d got com=%h pos=%0d exp com=%h pos=%0d",
                 n, o_com, o_pos, ec, k);
      end
    end
  endtask

  initial begin
    $display("[TB] fnd_scan_ctrl bench start");
    test_reset();
    test_scan();
    test_num_change();
    test_masks();
    test_hex();
    test_disable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
